// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit with register-file write-back.
// Optional MULDIV_FASTZERO_EN: trivial operations skip the iteration phase.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      rd,
   output logic            busy,
   output logic            we3,
   output logic [4:0]      wa3,
   output logic [XLEN-1:0] wd3,
   output logic [1:0]      dbg_state
);

   // start is a one-cycle request honoured only while busy is low; the
   // result appears on we3/wa3/wd3 for one cycle when the operation finishes.

   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [CW-1:0]     cnt;
   logic [1:0]        op_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   mcand;
   logic [XLEN-1:0]   divisor;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [2*XLEN-1:0] acc;

   logic              last;
   logic [XLEN:0]     sum;
   logic [2*XLEN-1:0] acc_nx;
   logic [XLEN:0]     shifted;
   logic              ge;
   logic [XLEN-1:0]   diff;
   logic [XLEN-1:0]   rem_nx;
   logic [XLEN-1:0]   quo_nx;
   logic [XLEN-1:0]   result_nx;
   logic              trivial;
   logic [XLEN-1:0]   trivial_res;

   assign last      = (cnt == CW'(XLEN - 1));
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   always_comb begin
      // Shift-add multiply: multiplier sits in the low half and drains out.
      sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
      acc_nx = {sum, acc[XLEN-1:1]};

      // Restoring divide; the true difference always fits in XLEN bits.
      shifted = {rem, quo[XLEN-1]};
      ge      = (shifted >= {1'b0, divisor});
      diff    = shifted[XLEN-1:0] - divisor;
      rem_nx  = ge ? diff : shifted[XLEN-1:0];
      quo_nx  = {quo[XLEN-2:0], ge};

      case (op_q)
         2'b00:   result_nx = acc_nx[XLEN-1:0];
         2'b01:   result_nx = acc_nx[2*XLEN-1:XLEN];
         2'b10:   result_nx = quo_nx;
         default: result_nx = rem_nx;
      endcase
   end

   always_comb begin
`ifdef MULDIV_FASTZERO_EN
      trivial = op[1] ? (b == '0) : ((a == '0) || (b == '0));
`else
      trivial = 1'b0;
`endif
      case (op)
         2'b10:   trivial_res = '1;
         2'b11:   trivial_res = a;
         default: trivial_res = '0;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = trivial ? DONE : RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         mcand   <= '0;
         divisor <= '0;
         quo     <= '0;
         rem     <= '0;
         acc     <= '0;
         we3     <= 1'b0;
         wa3     <= '0;
         wd3     <= '0;
      end else begin
         we3 <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q    <= op;
                  rd_q    <= rd;
                  mcand   <= a;
                  divisor <= b;
                  acc     <= {{XLEN{1'b0}}, b};
                  quo     <= a;
                  rem     <= '0;
                  cnt     <= '0;
                  if (trivial) begin
                     we3 <= (rd != 5'd0);
                     wa3 <= rd;
                     wd3 <= trivial_res;
                  end
               end
            end
            RUN: begin
               acc <= acc_nx;
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt + 1'b1;
               if (last) begin
                  cnt <= '0;
                  // x0 is hardwired zero: suppress the write but keep timing.
                  we3 <= (rd_q != 5'd0);
                  wa3 <= rd_q;
                  wd3 <= result_nx;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random operations
// scored against an arithmetic reference model through an expected queue.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  rd;
   logic        busy;
   logic        we3;
   logic [4:0]  wa3;
   logic [31:0] wd3;
   logic [1:0]  dbg_state;

`ifdef MULDIV_FASTZERO_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .rd(rd),
      .busy(busy), .we3(we3), .wa3(wa3), .wd3(wd3), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard
   logic [36:0] exp_q[$];
   int          exp_cyc_q[$];
   int          n_checks = 0;
   int          n_fail = 0;

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
      logic [63:0] p;
      p = {32'd0, x} * {32'd0, y};
      case (o)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic bit is_trivial(input logic [1:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
      if (!FAST) return 1'b0;
      return o[1] ? (y == 0) : (x == 0 || y == 0);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: every write must match the head of the expected queue
   always @(negedge clk) begin
      if (!reset && we3) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {59'd0, wa3}, 64'd0);
         end else begin
            logic [36:0] e;
            int          ec;
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("wa3", {59'd0, wa3}, {59'd0, e[36:32]});
            check("wd3", {32'd0, wd3}, {32'd0, e[31:0]});
            check("write_cycle", cyc, ec);
         end
      end
   end

   // driver: call at a negedge; returns at the negedge after the accept edge
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, input bit expect_write);
      int w;
      w = 0;
      while (busy && w < 200) begin
         w++;
         @(negedge clk);
      end
      if (busy) begin
         check("issue_timeout", {63'd0, busy}, 64'd0);
         return;
      end
      op = o; a = x; b = y; rd = r; start = 1'b1;
      if (expect_write && r != 0) begin
         exp_q.push_back({r, model(o, x, y)});
         exp_cyc_q.push_back(cyc + 1 + (is_trivial(o, x, y) ? 0 : 32));
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
   endtask

   task automatic busy_len(input string name, input int exp);
      int n;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check(name, n, exp);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; rd = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_we3", {63'd0, we3}, 64'd0);
      check("reset_wa3", {59'd0, wa3}, 64'd0);
      check("reset_wd3", {32'd0, wd3}, 64'd0);
      check("reset_state", {62'd0, dbg_state}, 64'd0);
      reset = 1'b0;
      @(negedge clk);

      issue(2'b00, 32'd7, 32'd6, 5'd5, 1'b1);
      busy_len("busy_mul", 33);
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1);
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b1);
      issue(2'b10, 32'd100, 32'd7, 5'd4, 1'b1);
      issue(2'b11, 32'd100, 32'd7, 5'd6, 1'b1);
      issue(2'b10, 32'h1234, 32'd0, 5'd7, 1'b1);
      busy_len("busy_div0", FAST ? 1 : 33);
      issue(2'b11, 32'h1234, 32'd0, 5'd8, 1'b1);
      busy_len("busy_rem0", FAST ? 1 : 33);

      // reset at E10 aborts the operation and clears the outputs
      issue(2'b00, 32'h1357, 32'h2468, 5'd9, 1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_we3", {63'd0, we3}, 64'd0);
      check("abort_wa3", {59'd0, wa3}, 64'd0);
      check("abort_wd3", {32'd0, wd3}, 64'd0);
      repeat (40) @(negedge clk);

      // a start at E5 with other operands must be ignored
      issue(2'b10, 32'd1000, 32'd9, 5'd10, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      op = 2'b00; a = 32'd5; b = 32'd5; rd = 5'd11; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      busy_len("busy_ignored_start", 28);

      // hardwired-zero destination: no write, same timing
      issue(2'b00, 32'd3, 32'd3, 5'd0, 1'b1);
      busy_len("busy_rd0", 33);
      issue(2'b00, 32'd12, 32'd12, 5'd1, 1'b1);

      issue(2'b01, 32'd0, 32'd55, 5'd12, 1'b1);
      issue(2'b00, 32'h89AB, 32'd0, 5'd13, 1'b1);

      for (int i = 0; i < 40; i++) begin
         logic [1:0]  o;
         logic [31:0] x;
         logic [31:0] y;
         int          sel;
         o   = 2'($urandom_range(0, 3));
         x   = $urandom;
         y   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) y = 32'd0;
         if (sel == 1) x = 32'd0;
         if (sel == 2) y = $urandom_range(1, 20);
         issue(o, x, y, 5'($urandom_range(0, 31)), 1'b1);
      end

      begin
         int w;
         w = 0;
         while (exp_q.size() != 0 && w < 200) begin
            w++;
            @(negedge clk);
         end
      end
      check("queue_drained", exp_q.size(), 64'd0);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
